prog_lut_decoder: RTL and testbench

Runtime-programmable instruction-field decoder: a bank of `NUM_LUTS` K-input lookup tables. Each table takes its address bits from a configurable selection of `in_data` bits and has a configurable truth table (`INIT`). Decode-logic cells are normally fixed at synthesis; this block lets the control plane reprogram decode functions in the field. Truth tables and selections are written into a shadow bank and committed atomically at a pipeline-drain boundary. The block sits between the fetch stage and the issue logic, with valid/ready handshakes on both sides.

---
 rtl/prog_lut_pkg.sv | 14 +
 rtl/prog_lut_cell.sv | 62 ++++++
 rtl/prog_lut_decoder.sv | 106 ++++++++++
 tb/tb_prog_lut_decoder.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_lut_pkg.sv
// prog_lut_pkg: shared types, config-field encodings and reset defaults for the LUT decoder.
package prog_lut_pkg;

    typedef enum logic [1:0] {RUN, DRAIN, SWAP} state_e;

    localparam logic CFG_INIT = 1'b0;
    localparam logic CFG_SEL  = 1'b1;

    // Default selection spreads consecutive LUT inputs across consecutive in_data bits.
    function automatic int sel_default(input int lut, input int j, input int k, input int in_w);
        return (lut * k + j) % in_w;
    endfunction

endpackage

// File: rtl/prog_lut_cell.sv
// prog_lut_cell: one K-input LUT with shadow/active INIT and SEL registers and address formation.
module prog_lut_cell
    import prog_lut_pkg::*;
#(
    parameter int LUT_K = 4,
    parameter int IN_W = 16,
    parameter int CFG_W = 16,
    parameter int IDX = 0,
    localparam int SEL_W = $clog2(IN_W),
    localparam int INIT_W = 2 ** LUT_K,
    localparam int SELS_W = LUT_K * SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              field_i,
    input  logic [CFG_W-1:0]  wdata_i,
    input  logic              swap_i,
    input  logic [IN_W-1:0]   in_data_i,
    output logic [LUT_K-1:0]  addr_o,
    output logic [INIT_W-1:0] init_o
);

    function automatic logic [SELS_W-1:0] sel_rst_vec();
        logic [SELS_W-1:0] v;
        v = '0;
        for (int j = 0; j < LUT_K; j++) v[j*SEL_W +: SEL_W] = SEL_W'(sel_default(IDX, j, LUT_K, IN_W));
        return v;
    endfunction

    localparam logic [SELS_W-1:0] SEL_RST = sel_rst_vec();

    logic [INIT_W-1:0] sh_init_q, act_init_q;
    logic [SELS_W-1:0] sh_sel_q, act_sel_q;

    // The swap copies the pre-edge shadow, so a write landing on the swap cycle waits for the next commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_init_q  <= '0;
            act_init_q <= '0;
            sh_sel_q   <= SEL_RST;
            act_sel_q  <= SEL_RST;
        end else begin
            if (we_i && field_i == CFG_INIT) sh_init_q <= wdata_i[INIT_W-1:0];
            if (we_i && field_i == CFG_SEL) sh_sel_q <= wdata_i[SELS_W-1:0];
            if (swap_i) begin
                act_init_q <= sh_init_q;
                act_sel_q  <= sh_sel_q;
            end
        end
    end

    always_comb begin
        addr_o = '0;
        for (int j = 0; j < LUT_K; j++) begin
            addr_o[j] = int'(act_sel_q[j*SEL_W +: SEL_W]) < IN_W && in_data_i[act_sel_q[j*SEL_W +: SEL_W]];
        end
    end

    assign init_o = act_init_q;

endmodule

// File: rtl/prog_lut_decoder.sv
// prog_lut_decoder: bank of runtime-programmable LUTs decoding an instruction field,
// two-stage valid/ready pipeline with drain-then-swap atomic configuration commit.
module prog_lut_decoder
    import prog_lut_pkg::*;
#(
    parameter int LUT_K = 4,
    parameter int NUM_LUTS = 8,
    parameter int IN_W = 16,
    localparam int SEL_W = $clog2(IN_W),
    localparam int CFG_W = (2 ** LUT_K > LUT_K * SEL_W) ? 2 ** LUT_K : LUT_K * SEL_W,
    // One spare bit so out-of-range LUT indices are representable and can be rejected.
    localparam int LUT_W = $clog2(NUM_LUTS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [IN_W-1:0]     in_data_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [NUM_LUTS-1:0] out_data_o,
    input  logic                cfg_we_i,
    input  logic [LUT_W-1:0]    cfg_lut_i,
    input  logic                cfg_field_i,
    input  logic [CFG_W-1:0]    cfg_wdata_i,
    input  logic                cfg_commit_i,
    output logic                cfg_busy_o
);

    logic [NUM_LUTS*LUT_K-1:0] addr_w, addr_q;
    logic [2**LUT_K-1:0]       init_w [NUM_LUTS];
    logic [NUM_LUTS-1:0]       out_d, out_q;
    logic                      s1_v_q, s2_v_q, s1_load, s2_load, accept, busy_q;
    state_e                    state_q;

    assign s2_load     = !s2_v_q || out_ready_i;
    assign s1_load     = !s1_v_q || s2_load;
    assign in_ready_o  = state_q == RUN && s1_load;
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = s2_v_q;
    assign out_data_o  = out_q;
    assign cfg_busy_o  = busy_q;

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        prog_lut_cell #(
            .LUT_K(LUT_K),
            .IN_W (IN_W),
            .CFG_W(CFG_W),
            .IDX  (i)
        ) u_cell (
            .clk      (clk),
            .rst_n    (rst_n),
            .we_i     (cfg_we_i && cfg_lut_i == LUT_W'(i)),
            .field_i  (cfg_field_i),
            .wdata_i  (cfg_wdata_i),
            .swap_i   (state_q == SWAP),
            .in_data_i(in_data_i),
            .addr_o   (addr_w[i*LUT_K +: LUT_K]),
            .init_o   (init_w[i])
        );
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_LUTS; i++) out_d[i] = init_w[i][addr_q[i*LUT_K +: LUT_K]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            addr_q <= '0;
            out_q  <= '0;
        end else begin
            if (s1_load) s1_v_q <= accept;
            if (accept) addr_q <= addr_w;
            if (s2_load) s2_v_q <= s1_v_q;
            if (s2_load && s1_v_q) out_q <= out_d;
        end
    end

    // Commits are only honoured in RUN; DRAIN waits for both stages to empty before the swap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: if (cfg_commit_i) begin
                    state_q <= DRAIN;
                    busy_q  <= 1'b1;
                end
                DRAIN: if (!s1_v_q && !s2_v_q) state_q <= SWAP;
                SWAP: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= RUN;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_lut_decoder.sv
// tb_prog_lut_decoder: directed stimulus with a bank-level reference model and a per-cycle output checker.
module tb_prog_lut_decoder;

    localparam int K = 4;
    localparam int N = 8;
    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_data;
    logic [7:0]  out_data;
    logic        cfg_we, cfg_field, cfg_commit, cfg_busy;
    logic [3:0]  cfg_lut;
    logic [15:0] cfg_wdata;

    int checks = 0;
    int errors = 0;

    prog_lut_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .cfg_we_i    (cfg_we),
        .cfg_lut_i   (cfg_lut),
        .cfg_field_i (cfg_field),
        .cfg_wdata_i (cfg_wdata),
        .cfg_commit_i(cfg_commit),
        .cfg_busy_o  (cfg_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: two banks of truth tables and selections, plus the in-flight result queue.
    logic [15:0] m_sh_init [N], m_act_init [N];
    int          m_sh_sel [N][K], m_act_sel [N][K];
    int          phase;
    logic [7:0]  exp_q [$];
    logic [7:0]  got [$];
    logic        hold_pending;
    logic [7:0]  held;

    function automatic logic [7:0] decode(input logic [15:0] d);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int a;
            a = 0;
            for (int j = 0; j < K; j++) begin
                int s;
                s = m_act_sel[i][j];
                if (s < W && d[s]) a += 1 << j;
            end
            r[i] = m_act_init[i][a];
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_sh_init[i]  = '0;
            m_act_init[i] = '0;
            for (int j = 0; j < K; j++) begin
                m_sh_sel[i][j]  = (i * K + j) % W;
                m_act_sel[i][j] = (i * K + j) % W;
            end
        end
        phase = 0;
        exp_q.delete();
        hold_pending = 1'b0;
    endtask

    // Sample one time unit before each rising edge and advance the model across that edge.
    always @(negedge clk) begin
        #4;
        if (!rst_n) model_reset();
        else begin
            int pre;
            if (hold_pending) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, held);
            end
            hold_pending = out_valid && !out_ready;
            held = out_data;
            chk("busy", cfg_busy, phase != 0);
            if (phase != 0) chk("ready_while_busy", in_ready, 1'b0);
            pre = exp_q.size();
            if (out_valid && out_ready) begin
                chk("out_data", out_data, exp_q.size() > 0 ? exp_q[0] : 8'hxx);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                got.push_back(out_data);
            end
            if (phase == 2) begin
                for (int i = 0; i < N; i++) begin
                    m_act_init[i] = m_sh_init[i];
                    for (int j = 0; j < K; j++) m_act_sel[i][j] = m_sh_sel[i][j];
                end
                phase = 0;
            end else if (phase == 1 && pre == 0) phase = 2;
            else if (phase == 0 && cfg_commit) phase = 1;
            if (cfg_we && cfg_lut < N) begin
                if (cfg_field) for (int j = 0; j < K; j++) m_sh_sel[cfg_lut][j] = int'(cfg_wdata[j*4 +: 4]);
                else m_sh_init[cfg_lut] = cfg_wdata;
            end
            if (in_valid && in_ready) exp_q.push_back(decode(in_data));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_wr(input logic [3:0] lut, input logic field, input logic [15:0] d);
        cfg_we = 1'b1;
        cfg_lut = lut;
        cfg_field = field;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic send(input logic [15:0] d);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        for (int n = 0; n < 50 && !acc; n++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain_wait();
        logic idle;
        idle = 1'b0;
        for (int n = 0; n < 50 && !idle; n++) begin
            idle = !cfg_busy && exp_q.size() == 0 && !out_valid;
            if (!idle) tick();
        end
        if (!idle) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    task automatic chk_got(input string name, input int idx, input logic [7:0] exp);
        chk(name, got.size() > idx ? got[idx] : 8'hxx, exp);
    endtask

    initial begin
        int gi;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        cfg_we = 1'b0;
        cfg_lut = '0;
        cfg_field = 1'b0;
        cfg_wdata = '0;
        cfg_commit = 1'b0;
        model_reset();
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", cfg_busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // Reset bank decodes everything to zero, two cycles after acceptance.
        send(16'hFFFF);
        chk("lat_t1", out_valid, 1'b0);
        tick();
        chk("lat_t2_valid", out_valid, 1'b1);
        chk("lat_t2_data", out_data, 8'h00);
        tick();

        // Program LUT0 and commit on an empty pipeline.
        cfg_wr(4'd0, 1'b0, 16'h5054);
        commit();
        chk("commit_drain_busy", cfg_busy, 1'b1);
        chk("commit_drain_ready", in_ready, 1'b0);
        tick();
        chk("commit_swap_busy", cfg_busy, 1'b1);
        chk("commit_swap_ready", in_ready, 1'b0);
        tick();
        chk("commit_run_busy", cfg_busy, 1'b0);
        chk("commit_run_ready", in_ready, 1'b1);
        gi = got.size();
        send(16'h0002);
        send(16'h0001);
        drain_wait();
        chk_got("lut0_addr2", gi, 8'h01);
        chk_got("lut0_addr1", gi + 1, 8'h00);

        // Commit with two results stalled in the pipeline.
        cfg_wr(4'd0, 1'b0, 16'hFFFF);
        gi = got.size();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0002;
        tick();
        in_data = 16'h0001;
        tick();
        in_valid = 1'b0;
        commit();
        in_valid = 1'b1;
        in_data = 16'h0003;
        for (int n = 0; n < 3; n++) begin
            chk("stall_busy", cfg_busy, 1'b1);
            chk("stall_ready", in_ready, 1'b0);
            chk("stall_data", out_data, 8'h01);
            tick();
        end
        out_ready = 1'b1;
        send(16'h0003);
        drain_wait();
        chk_got("inflight_a_old", gi, 8'h01);
        chk_got("inflight_b_old", gi + 1, 8'h00);
        chk_got("after_swap_new", gi + 2, 8'h01);

        // SEL remap of LUT3 onto the top nibble.
        cfg_wr(4'd3, 1'b1, 16'hFEDC);
        cfg_wr(4'd3, 1'b0, 16'h8000);
        commit();
        gi = got.size();
        send(16'hF000);
        send(16'h7000);
        drain_wait();
        chk_got("remap_f000", gi, 8'h09);
        chk_got("remap_7000", gi + 1, 8'h01);
        chk("model_pin_f000", decode(16'hF000), 8'h09);
        chk("model_pin_7000", decode(16'h7000), 8'h01);

        // Commit held into DRAIN is ignored; a write on the SWAP cycle waits for the next commit.
        cfg_commit = 1'b1;
        tick();
        chk("ign_drain_busy", cfg_busy, 1'b1);
        tick();
        chk("ign_swap_busy", cfg_busy, 1'b1);
        cfg_commit = 1'b0;
        cfg_we = 1'b1;
        cfg_lut = 4'd5;
        cfg_field = 1'b0;
        cfg_wdata = 16'hFFFF;
        tick();
        cfg_we = 1'b0;
        chk("ign_run_busy", cfg_busy, 1'b0);
        gi = got.size();
        send(16'h0000);
        drain_wait();
        chk_got("swap_write_pending", gi, 8'h01);
        cfg_wr(4'd8, 1'b0, 16'hFFFF);
        cfg_wr(4'd8, 1'b1, 16'h0000);
        commit();
        send(16'h0000);
        drain_wait();
        chk_got("second_commit", gi + 1, 8'h21);

        // Reset during DRAIN discards the pending commit and both banks.
        out_ready = 1'b0;
        cfg_wr(4'd1, 1'b0, 16'hFFFF);
        send(16'hFFFF);
        commit();
        chk("pre_rst_busy", cfg_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", cfg_busy, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_data", out_data, 8'h00);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        gi = got.size();
        send(16'hFFFF);
        drain_wait();
        chk_got("post_rst_active", gi, 8'h00);
        commit();
        send(16'hFFFF);
        drain_wait();
        chk_got("post_rst_shadow", gi + 1, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
